// File: rtl/cache_block_transfer_ctrl_if.sv
// Bundle of request-side, cache-way and memory-bus signals for cache_block_transfer_ctrl.
// master = the controller's view, slave = the cache/memory environment's view.
interface cache_block_transfer_ctrl_if #(
    parameter int TAGBITS = 14
);
    // request side (hit/miss logic)
    logic               Req;
    logic [31:0]        ReqA;
    logic               Busy;
    logic               Done;

    // cache way
    logic               WayRV;
    logic               WayDirty;
    logic [TAGBITS-1:0] WayRTag;
    logic [127:0]       WayRD;
    logic               WayWE;
    logic               WayDirtyIn;
    logic [31:0]        WayA;
    logic [31:0]        WayWD;
    logic [3:0]         WayByteMask;

    // next-level memory bus
    logic               MemReq;
    logic               MemWrite;
    logic [31:0]        MemA;
    logic [31:0]        MemWD;
    logic [31:0]        MemRD;
    logic               MemReady;

    modport master (
        input  Req, ReqA,
        output Busy, Done,
        input  WayRV, WayDirty, WayRTag, WayRD,
        output WayWE, WayDirtyIn, WayA, WayWD, WayByteMask,
        output MemReq, MemWrite, MemA, MemWD,
        input  MemRD, MemReady
    );

    modport slave (
        output Req, ReqA,
        input  Busy, Done,
        output WayRV, WayDirty, WayRTag, WayRD,
        input  WayWE, WayDirtyIn, WayA, WayWD, WayByteMask,
        input  MemReq, MemWrite, MemA, MemWD,
        output MemRD, MemReady
    );
endinterface

// File: rtl/cache_block_transfer_ctrl.sv
// Miss controller: optional dirty-victim writeback, then word-serial block fill into one cache way.
// Build option: define CACHE_BLOCK_TRANSFER_CWF_EN to start the fill at the requested word.
module cache_block_transfer_ctrl #(
    parameter int LINES   = 16384,
    parameter int TAGBITS = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    cache_block_transfer_ctrl_if.master bus
);
    localparam int SETBITS = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state_reg;
    logic [1:0]         beat_reg;
    logic [1:0]         start_reg;
    logic [TAGBITS-1:0] vtag_reg;
    logic [TAGBITS-1:0] rtag_reg;
    logic [SETBITS-1:0] set_reg;
    logic [127:0]       victim_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               mem_req_reg;
    logic               mem_write_reg;

    logic [31:0]        victim_word [4];
    logic [1:0]         beat_inc;
    logic [1:0]         start_word;
    logic               victim_dirty;
    logic [31:0]        wb_addr;
    logic [31:0]        fill_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_victim_word
            assign victim_word[gi] = victim_reg[32*gi +: 32];
        end
    endgenerate

`ifdef CACHE_BLOCK_TRANSFER_CWF_EN
    assign start_word = bus.ReqA[3:2];
`else
    assign start_word = 2'd0;
`endif

    // A dirty bit on an invalid line carries no data worth saving.
    assign victim_dirty = bus.WayRV & bus.WayDirty;
    assign beat_inc     = beat_reg + 2'd1;
    assign wb_addr      = {vtag_reg, set_reg, beat_reg, 2'b00};
    assign fill_addr    = {rtag_reg, set_reg, beat_reg, 2'b00};

    assign bus.Busy     = busy_reg;
    assign bus.Done     = done_reg;
    assign bus.MemReq   = mem_req_reg;
    assign bus.MemWrite = mem_write_reg;

    // Address/data follow the registered beat counter, so they hold until the beat is accepted.
    always_comb begin
        bus.MemA        = 32'd0;
        bus.MemWD       = 32'd0;
        bus.WayA        = bus.ReqA;
        bus.WayWE       = 1'b0;
        bus.WayWD       = 32'd0;
        bus.WayByteMask = 4'h0;
        bus.WayDirtyIn  = 1'b0;
        case (state_reg)
            WRITEBACK: begin
                bus.MemA  = wb_addr;
                bus.MemWD = victim_word[beat_reg];
            end
            FILL: begin
                bus.MemA = fill_addr;
                bus.WayA = fill_addr;
                if (bus.MemReady) begin
                    bus.WayWE       = 1'b1;
                    bus.WayWD       = bus.MemRD;
                    bus.WayByteMask = 4'hF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_reg      <= 2'd0;
            start_reg     <= 2'd0;
            vtag_reg      <= '0;
            rtag_reg      <= '0;
            set_reg       <= '0;
            victim_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.Req) begin
                        victim_reg  <= bus.WayRD;
                        vtag_reg    <= bus.WayRTag;
                        rtag_reg    <= bus.ReqA[31:32-TAGBITS];
                        set_reg     <= bus.ReqA[SETBITS+3:4];
                        start_reg   <= start_word;
                        busy_reg    <= 1'b1;
                        mem_req_reg <= 1'b1;
                        if (victim_dirty) begin
                            state_reg     <= WRITEBACK;
                            mem_write_reg <= 1'b1;
                            beat_reg      <= 2'd0;
                        end else begin
                            state_reg     <= FILL;
                            mem_write_reg <= 1'b0;
                            beat_reg      <= start_word;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.MemReady) begin
                        if (beat_reg == 2'd3) begin
                            state_reg     <= FILL;
                            mem_write_reg <= 1'b0;
                            beat_reg      <= start_reg;
                        end else begin
                            beat_reg <= beat_inc;
                        end
                    end
                end
                FILL: begin
                    if (bus.MemReady) begin
                        beat_reg <= beat_inc;
                        // Four beats have gone once the counter wraps back to the start word.
                        if (beat_inc == start_reg) begin
                            state_reg   <= DONE;
                            mem_req_reg <= 1'b0;
                            done_reg    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_block_transfer_ctrl.sv
// Self-checking bench for cache_block_transfer_ctrl: directed and random misses against a
// beat-list model of the expected bus traffic and a word-per-address memory image.
module tb_cache_block_transfer_ctrl;
    localparam int LINES   = 16384;
    localparam int TAGBITS = 14;
    localparam int SETBITS = $clog2(LINES);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;
    logic [31:0] salt;

    cache_block_transfer_ctrl_if #(.TAGBITS(TAGBITS)) bus ();

    cache_block_transfer_ctrl #(.LINES(LINES), .TAGBITS(TAGBITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } beat_t;

    // Memory contents: every word address holds a salted hash of itself.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn, obs, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag, input logic [31:0] reqa);
        check({tag, "_busy"},   bus.Busy, 1'b0);
        check({tag, "_done"},   bus.Done, 1'b0);
        check({tag, "_memreq"}, bus.MemReq, 1'b0);
        check({tag, "_memwr"},  bus.MemWrite, 1'b0);
        check({tag, "_we"},     bus.WayWE, 1'b0);
        check({tag, "_dirtyin"}, bus.WayDirtyIn, 1'b0);
        check({tag, "_mema"},   bus.MemA, 32'd0);
        check({tag, "_memwd"},  bus.MemWD, 32'd0);
        check({tag, "_waywd"},  bus.WayWD, 32'd0);
        check({tag, "_mask"},   bus.WayByteMask, 4'h0);
        check({tag, "_waya"},   bus.WayA, reqa);
    endtask

    // One miss: drive Req, play the memory, check every beat and the final way contents.
    task automatic run_miss(input logic [31:0] addr, input logic rv, input logic dirty,
                            input logic [TAGBITS-1:0] vtag, input logic [127:0] vdata,
                            input int stall_fixed, input int stall_rand,
                            input int abort_after, input logic pulse_req);
        beat_t              exp_q[$];
        logic [31:0]        installed [4];
        logic [1:0]         start;
        logic [1:0]         w2;
        logic [SETBITS-1:0] set_f;
        logic [TAGBITS-1:0] rtag;
        int                 nbeats, stall_left, stall_total, cnt, accepted;
        logic               done_seen;

        txn++;
        set_f = addr[SETBITS+3:4];
        rtag  = addr[31:32-TAGBITS];
`ifdef CACHE_BLOCK_TRANSFER_CWF_EN
        start = addr[3:2];
`else
        start = 2'd0;
`endif
        if (rv && dirty) begin
            for (int w = 0; w < 4; w++) begin
                w2 = w[1:0];
                exp_q.push_back('{1'b1, {vtag, set_f, w2, 2'b00}, vdata[32*w +: 32]});
            end
        end
        for (int i = 0; i < 4; i++) begin
            w2 = start + i[1:0];
            exp_q.push_back('{1'b0, {rtag, set_f, w2, 2'b00}, 32'd0});
        end
        nbeats = exp_q.size();
        for (int w = 0; w < 4; w++) installed[w] = 'x;

        @(negedge clk);
        bus.ReqA     = addr;
        bus.WayRV    = rv;
        bus.WayDirty = dirty;
        bus.WayRTag  = vtag;
        bus.WayRD    = vdata;
        bus.Req      = 1'b1;
        bus.MemReady = 1'b0;
        #1;
        check("idle_waya", bus.WayA, addr);
        check("idle_busy", bus.Busy, 1'b0);

        cnt         = 1;
        accepted    = 0;
        done_seen   = 1'b0;
        stall_left  = stall_fixed + $urandom_range(stall_rand, 0);
        stall_total = stall_left;
        while (!done_seen && cnt < 400) begin
            @(negedge clk);
            cnt++;
            bus.Req = 1'b0;
            if (pulse_req && accepted == nbeats - 2) begin
                bus.Req  = 1'b1;
                bus.ReqA = addr ^ 32'hFFFF_0000;
            end
            if (abort_after >= 0 && accepted == abort_after) begin
                bus.MemReady = 1'b1;
                reset = 1'b1;
                #1;
                check_quiet_outputs("rst_mid", bus.ReqA);
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check("rst_hold_we", bus.WayWE, 1'b0);
                    check("rst_hold_memreq", bus.MemReq, 1'b0);
                end
                reset = 1'b0;
                $display("txn %0d: addr=%08h aborted by reset after %0d beats", txn, addr, accepted);
                return;
            end
            bus.MemReady = (stall_left == 0);
            #1;
            bus.MemRD = mem_word(bus.MemA);
            #1;
            check("busy", bus.Busy, 1'b1);
            if (cnt == 2) check("first_req", bus.MemReq, 1'b1);
            if (bus.MemReq) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", bus.MemReq, 1'b0);
                end else begin
                    check("mem_write", bus.MemWrite, exp_q[0].wr);
                    check("mem_a", bus.MemA, exp_q[0].a);
                    if (exp_q[0].wr) check("mem_wd", bus.MemWD, exp_q[0].d);
                    if (bus.MemReady) begin
                        check("way_we", bus.WayWE, !exp_q[0].wr);
                        if (!exp_q[0].wr) begin
                            check("way_a", bus.WayA, exp_q[0].a);
                            check("way_wd", bus.WayWD, mem_word(exp_q[0].a));
                            check("way_mask", bus.WayByteMask, 4'hF);
                            check("way_dirty_in", bus.WayDirtyIn, 1'b0);
                        end
                        void'(exp_q.pop_front());
                        accepted++;
                        if (exp_q.size() > 0) begin
                            stall_left   = stall_fixed + $urandom_range(stall_rand, 0);
                            stall_total += stall_left;
                        end
                    end else begin
                        check("way_we_stall", bus.WayWE, 1'b0);
                        stall_left--;
                    end
                end
            end else begin
                check("way_we_noreq", bus.WayWE, 1'b0);
                if (bus.Done) begin
                    done_seen = 1'b1;
                    check("done_cycle", cnt, 2 + nbeats + stall_total);
                    check("beats_left", exp_q.size(), 0);
                end
            end
            if (bus.WayWE) installed[bus.WayA[3:2]] = bus.WayWD;
        end
        check("done_seen", done_seen, 1'b1);

        @(negedge clk);
        bus.Req = 1'b0;
        #2;
        check("done_pulse", bus.Done, 1'b0);
        check("busy_after", bus.Busy, 1'b0);
        check("memreq_after", bus.MemReq, 1'b0);
        for (int w = 0; w < 4; w++) begin
            w2 = w[1:0];
            check("installed", installed[w], mem_word({rtag, set_f, w2, 2'b00}));
        end
        $display("txn %0d: addr=%08h rv=%0d dirty=%0d beats=%0d stalls=%0d done_cycle=%0d",
                 txn, addr, rv, dirty, nbeats, stall_total, cnt);
    endtask

    logic [31:0]  dirty_addr;
    logic [127:0] dirty_data;
    logic [31:0]  r_addr, r_tag, r_flags;
    logic [127:0] r_data;

    initial begin
        salt         = $urandom;
        bus.Req      = 1'b0;
        bus.ReqA     = 32'hDEAD_BEE0;
        bus.WayRV    = 1'b0;
        bus.WayDirty = 1'b0;
        bus.WayRTag  = '0;
        bus.WayRD    = '0;
        bus.MemRD    = 32'd0;
        bus.MemReady = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet_outputs("reset", 32'hDEAD_BEE0);
        reset = 1'b0;

        dirty_addr = {14'h0ABC, 14'h123, 2'b01, 2'b00};
        dirty_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // clean miss, then dirty miss, then a dirty miss stalled 3 cycles before every beat
        run_miss(32'h0000_1238, 1'b0, 1'b0, 14'h0, 128'h0, 0, 0, -1, 1'b0);
        run_miss(dirty_addr, 1'b1, 1'b1, 14'h2A5, dirty_data, 0, 0, -1, 1'b0);
        run_miss(dirty_addr, 1'b1, 1'b1, 14'h2A5, dirty_data, 3, 0, -1, 1'b0);
        // dirty but invalid is clean; valid but clean needs no writeback
        run_miss(32'h1357_9ABC, 1'b0, 1'b1, 14'h1FF, dirty_data, 0, 0, -1, 1'b0);
        run_miss(32'h2468_ACE4, 1'b1, 1'b0, 14'h3FF, dirty_data, 0, 0, -1, 1'b0);
        // requested word 2: fill order depends on the critical-word-first build
        run_miss(32'h0004_5678, 1'b0, 1'b0, 14'h0, 128'h0, 0, 0, -1, 1'b0);
        // reset after the second writeback beat, then a normal miss
        run_miss(dirty_addr, 1'b1, 1'b1, 14'h2A5, dirty_data, 0, 0, 2, 1'b0);
        run_miss(dirty_addr, 1'b1, 1'b1, 14'h2A5, dirty_data, 0, 0, -1, 1'b0);
        // Req pulsed mid-fill with another address
        run_miss(32'h0ABC_1230, 1'b0, 1'b0, 14'h0, 128'h0, 0, 0, -1, 1'b1);

        for (int i = 0; i < 10; i++) begin
            r_addr  = $urandom;
            r_tag   = $urandom;
            r_flags = $urandom;
            r_data  = {$urandom, $urandom, $urandom, $urandom};
            run_miss(r_addr, r_flags[0], r_flags[1], r_tag[TAGBITS-1:0], r_data, 0, 2, -1, r_flags[2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
